prog_loader: RTL and testbench

//  Boot-time writer for the 256x16 instruction memory that the pipelined cpu reads from.
//  - Receives a byte stream over a valid/ready interface.
//  - Assembles big-endian 16-bit words and writes them sequentially from address 0.
//  - Holds the cpu in reset (cpu_hold) until the whole image is written.
//  - Sits between the host byte source (UART rx / testbench) and inst-memory write port.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader.sv | 79 +++++++
 tb/tb_prog_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: state encoding and length-header decode shared by the boot loader.
package prog_loader_pkg;
  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_t;
  localparam int LEN_BYTES = 2;
  function automatic state_t len_next(input logic [8*LEN_BYTES-1:0] n, input int unsigned cap);
    return n == '0 ? DONE : 32'(n) > cap ? ERR : DATA_HI;
  endfunction
endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed big-endian word image into inst memory while holding the cpu.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              err_len,
  output logic [ADDR_W:0]   word_count
);
  state_t state, state_d;
  logic xfer;
  logic [15:0] len;
  logic [7:0] hi;
  logic [ADDR_W-1:0] idx;
  assign in_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
  assign xfer = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= LEN_HI;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      LEN_HI:  state_d = xfer ? LEN_LO : LEN_HI;
      LEN_LO:  state_d = xfer ? len_next({len[15:8], in_byte}, 1 << ADDR_W) : LEN_LO;
      DATA_HI: state_d = xfer ? DATA_LO : DATA_HI;
      DATA_LO: state_d = xfer ? WRITE : DATA_LO;
      WRITE:   state_d = 16'(word_count) + 16'd1 == len ? DONE : DATA_HI;
      DONE:    state_d = reload ? LEN_HI : DONE;
      ERR:     state_d = reload ? LEN_HI : ERR;
      default: state_d = LEN_HI;
    endcase
  end
  // Status outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      err_len    <= 1'b0;
      word_count <= '0;
      len        <= '0;
      hi         <= '0;
      idx        <= '0;
    end else begin
      mem_wen   <= state_d == WRITE;
      cpu_hold  <= state_d != DONE;
      load_done <= state_d == DONE;
      err_len   <= state_d == ERR;
      if (xfer && state == LEN_HI) len[15:8] <= in_byte;
      if (xfer && state == LEN_LO) len[7:0] <= in_byte;
      if (xfer && state == DATA_HI) hi <= in_byte;
      if (xfer && state == DATA_LO) begin
        mem_addr  <= idx;
        mem_wdata <= {hi, in_byte};
      end
      if (state == WRITE) begin
        idx        <= idx + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (reload && state inside {DONE, ERR}) begin
        idx        <= '0;
        word_count <= '0;
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed, table-driven and random image loads checked against a stream-level model.
module tb_prog_loader;
  logic clk = 0, rst = 0, in_valid = 0, reload = 0;
  logic [7:0] in_byte = 0;
  logic in_ready, mem_wen, cpu_hold, load_done, err_len;
  logic [7:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0] word_count;
  int total = 0, passed = 0;
  logic [23:0] wq[$], eq[$];
  logic [7:0] bq[$];
  logic prev_wen = 0;
  typedef struct { logic [15:0] n; int gap; bit done; bit err; int cnt; } vec_t;
  vec_t tbl[6];

  prog_loader dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .reload(reload), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .err_len(err_len), .word_count(word_count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  always @(negedge clk) begin
    if (mem_wen) begin
      wq.push_back({mem_addr, mem_wdata});
      chk("wen_single_cycle", {31'd0, prev_wen}, 0);
    end
    prev_wen <= mem_wen;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(99) < gap) begin
        in_valid = 0;
        in_byte = 8'($urandom);
        @(negedge clk);
      end else begin
        in_valid = 1;
        in_byte = b;
        if (in_ready) begin
          @(negedge clk);
          in_valid = 0;
          return;
        end
        @(negedge clk);
      end
    end
    chk("send_timeout", 1, 0);
  endtask

  task automatic do_reload();
    reload = 1;
    @(negedge clk);
    reload = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_wen"}, mem_wen, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, err_len, 0);
    chk({tag, "_wc"}, word_count, 0);
  endtask

  // Expected writes come straight from the stream format: header N, then N hi/lo pairs at addr 0..N-1.
  task automatic run_load(input int gap, input bit e_done, input bit e_err, input int e_cnt, input string tag);
    int n;
    n = {bq[0], bq[1]};
    eq.delete();
    wq.delete();
    if (n != 0 && n <= 256)
      for (int i = 0; i < n; i++) eq.push_back({8'(i), bq[2+2*i], bq[3+2*i]});
    foreach (bq[i]) send_byte(bq[i], gap);
    for (int i = 0; i < 20 && !(load_done || err_len); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_nwrites"}, wq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < wq.size(); i++) chk({tag, "_write"}, wq[i], eq[i]);
    chk({tag, "_done"}, load_done, e_done);
    chk({tag, "_err"}, err_len, e_err);
    chk({tag, "_hold"}, cpu_hold, !e_done);
    chk({tag, "_wc"}, word_count, e_cnt);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic build(input logic [15:0] n, input int words);
    bq.delete();
    bq.push_back(n[15:8]);
    bq.push_back(n[7:0]);
    for (int i = 0; i < 2 * words; i++) bq.push_back(8'($urandom));
  endtask

  initial begin
    tbl[0] = '{16'd0,    0,  1, 0, 0};
    tbl[1] = '{16'd257,  0,  0, 1, 0};
    tbl[2] = '{16'd256,  0,  1, 0, 256};
    tbl[3] = '{16'd5,    50, 1, 0, 5};
    tbl[4] = '{16'hFFFF, 20, 0, 1, 0};
    tbl[5] = '{16'd1,    30, 1, 0, 1};
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1;
    @(negedge clk);
    // Spec image with exact constants and write latency on the last word.
    bq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    wq.delete();
    foreach (bq[i]) send_byte(bq[i], 0);
    chk("t1_latency_wen", mem_wen, 1);
    chk("t1_latency_addr", mem_addr, 2);
    chk("t1_latency_data", mem_wdata, 16'h0001);
    @(negedge clk);
    chk("t1_nwrites", wq.size(), 3);
    if (wq.size() == 3) begin
      chk("t1_w0", wq[0], 24'h001234);
      chk("t1_w1", wq[1], 24'h01ABCD);
      chk("t1_w2", wq[2], 24'h020001);
    end
    chk("t1_done", load_done, 1);
    chk("t1_hold", cpu_hold, 0);
    chk("t1_wc", word_count, 3);
    // Same image with random source gaps.
    do_reload();
    run_load(50, 1, 0, 3, "t5");
    // Reload coincident with a valid byte in DONE: reload wins, byte taken next cycle as LEN_HI.
    reload = 1;
    in_valid = 1;
    in_byte = 8'h00;
    @(negedge clk);
    reload = 0;
    chk("rl_in_ready", in_ready, 1);
    chk("rl_done", load_done, 0);
    chk("rl_hold", cpu_hold, 1);
    chk("rl_wc", word_count, 0);
    @(negedge clk);
    in_valid = 0;
    chk("rl_byte_taken", in_ready, 1);
    bq = '{8'h00, 8'h01, 8'h5A, 8'hC3};
    wq.delete();
    for (int i = 1; i < 4; i++) send_byte(bq[i], 0);
    repeat (2) @(negedge clk);
    chk("rl_nwrites", wq.size(), 1);
    if (wq.size() == 1) chk("rl_w0", wq[0], 24'h005AC3);
    chk("rl_done2", load_done, 1);
    // ERR holds across attempted bytes until reload.
    do_reload();
    build(16'd257, 0);
    run_load(0, 0, 1, 0, "t3");
    in_valid = 1;
    repeat (5) @(negedge clk);
    in_valid = 0;
    chk("t3_hold_ready", in_ready, 0);
    chk("t3_hold_err", err_len, 1);
    chk("t3_no_writes", wq.size(), 0);
    foreach (tbl[k]) begin
      do_reload();
      build(tbl[k].n, (tbl[k].n <= 256) ? int'(tbl[k].n) : 0);
      run_load(tbl[k].gap, tbl[k].done, tbl[k].err, tbl[k].cnt, $sformatf("tbl%0d", k));
    end
    for (int r = 0; r < 4; r++) begin
      logic [15:0] n;
      n = 16'($urandom_range(0, 300));
      do_reload();
      build(n, (n <= 256) ? int'(n) : 0);
      run_load($urandom_range(0, 60), n <= 256, n > 256, (n <= 256) ? int'(n) : 0, $sformatf("rnd%0d", r));
    end
    // Async reset mid-load, then a fresh load restarts at addr 0.
    do_reload();
    bq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
    foreach (bq[i]) send_byte(bq[i], 0);
    #2 rst = 0;
    #1 check_reset_vals("arst");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    bq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    run_load(0, 1, 0, 1, "t6");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
